// File: rtl/four_bit_sync_cntr_beh_pkg.sv
// Shared constants for the synchronous counter building block and its cascade wrapper.
package four_bit_sync_cntr_beh_pkg;

    localparam int CNT_WIDTH = 4;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

endpackage

// File: rtl/cntr_cascade.sv
// Chains N counter stages through carry -> cnt_en to form a wider synchronous counter.
module cntr_cascade
    import four_bit_sync_cntr_beh_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                   rstn,
    input  logic                   clk,
    input  logic                   cnt_en,
    output logic [N*CNT_WIDTH-1:0] count,
    output logic                   carry
);

    logic [N:0] en_chain;

    assign en_chain[0] = cnt_en;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_stage
            four_bit_sync_cntr_beh #(.WIDTH(CNT_WIDTH)) u_stage (
                rstn,
                clk,
                en_chain[gi],
                count[gi*CNT_WIDTH +: CNT_WIDTH],
                en_chain[gi+1]
            );
        end
    endgenerate

    assign carry = en_chain[N];

endmodule

// File: rtl/four_bit_sync_cntr_beh.sv
// Synchronous up-counter with count enable and a combinational terminal-count carry
// that drives the next stage's enable when stages are chained.
module four_bit_sync_cntr_beh
    import four_bit_sync_cntr_beh_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             rstn,
    input  logic             clk,
    input  logic             cnt_en,
    output logic [WIDTH-1:0] count,
    output logic             carry
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg + ONE;
    end

    // Reset wins over enable; the all-ones value wraps naturally to zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_reg <= '0;
        end else if (cnt_en) begin
            count_reg <= count_next;
        end
    end

    // Left unregistered so an upper stage advances on the same edge this stage wraps.
    assign carry = cnt_en & (count_reg == MAX_VAL);
    assign count = count_reg;

endmodule

// File: tb/tb_four_bit_sync_cntr_beh.sv
// Scoreboard bench: the driver queues expected values from a running tick total, a monitor pops and compares.
module tb_four_bit_sync_cntr_beh;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cnt_en = 1'b0;
    logic [3:0] count;
    logic       carry;
    logic [7:0] ccount;
    logic       ccarry;

    typedef struct {
        logic [3:0] cnt;
        logic       cy;
        logic [7:0] ccnt;
        logic       ccy;
        int         phase;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;
    int   ticks = 0;
    int   phase = 0;
    bit   stim_done = 1'b0;

    always #5 clk = ~clk;

    four_bit_sync_cntr_beh #(.WIDTH(4)) dut (
        .rstn   (rstn),
        .clk    (clk),
        .cnt_en (cnt_en),
        .count  (count),
        .carry  (carry)
    );

    cntr_cascade #(.N(2)) dut_casc (
        .rstn   (rstn),
        .clk    (clk),
        .cnt_en (cnt_en),
        .count  (ccount),
        .carry  (ccarry)
    );

    // Reference: total enabled ticks since reset; the counters are that total mod 16 / mod 256.
    task automatic step(input logic r, input logic e);
        exp_t x;
        rstn   = r;
        cnt_en = e;
        x.cnt   = 4'(ticks % 16);
        x.cy    = e && (ticks % 16 == 15);
        x.ccnt  = 8'(ticks % 256);
        x.ccy   = e && (ticks % 256 == 255);
        x.phase = phase;
        sb.push_back(x);
        if (!r) ticks = 0;
        else if (e) ticks = ticks + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1);
    endtask

    task automatic run_en(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s txn=%0d actual=%h required=%h", name, txn, act, req);
        end
    endtask

    // Monitor: compares mid-cycle, away from the rising edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("count", {4'h0, count}, {4'h0, x.cnt});
                check("carry", {7'h0, carry}, {7'h0, x.cy});
                check("cascade_count", ccount, x.ccnt);
                check("cascade_carry", {7'h0, ccarry}, {7'h0, x.ccy});
                $display("txn %0d phase %0d rstn=%b en=%b count=%h carry=%b ccount=%h ccarry=%b",
                         txn, x.phase, rstn, cnt_en, count, carry, ccount, ccarry);
                txn++;
            end
        end
    end

    initial begin
        // Establish a defined state before anything is queued.
        rstn   = 1'b0;
        cnt_en = 1'b1;
        @(posedge clk);
        #1;

        phase = 1;  // reset held with enable high, then release
        repeat (3) step(1'b0, 1'b1);
        run_en(2);

        phase = 2;  // full sweep through the wrap
        do_reset();
        run_en(17);

        phase = 3;  // enable hold at 5
        do_reset();
        run_en(5);
        repeat (4) step(1'b1, 1'b0);
        run_en(2);

        phase = 4;  // carry gating at F
        do_reset();
        run_en(15);
        repeat (2) step(1'b1, 1'b0);
        run_en(2);

        phase = 5;  // mid-run reset at A
        do_reset();
        run_en(10);
        step(1'b0, 1'b1);
        run_en(2);

        phase = 6;  // random enable with occasional reset
        for (int i = 0; i < 100; i++) begin
            step(($urandom % 32) != 0, 1'($urandom % 2));
        end

        phase = 7;  // cascade wrap through 255
        do_reset();
        run_en(260);
        step(1'b1, 1'b0);

        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!stim_done && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (!stim_done || sb.size() != 0) begin
            errors++;
            $display("FAIL drain actual_pending=%0d required_pending=0 done=%0d", sb.size(), stim_done);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/four_bit_sync_cntr_beh.md
Name: four_bit_sync_cntr_beh

Overview:
- 4-bit synchronous up-counter with count enable and a cascadable carry (terminal-count) output.
- Leaf building block. Several instances chain into wider counters by driving the next stage's cnt_en from this stage's carry.
- All stages share one clock.

Parameters:
- WIDTH, 4, counter width in bits. The block is specified and verified at 4; other values follow the same rules with max = 2^WIDTH-1.

Ports:
- Declaration (positional) order is rstn, clk, cnt_en, count, carry. Instantiations connect by position.
- rstn  input  1  synchronous active-low reset, sampled on rising clk.
- clk  input  1  single clock; all state updates on its rising edge.
- cnt_en  input  1  count enable; when high, the counter increments on the next rising clk.
- count  output  WIDTH  current counter value, registered.
- carry  output  1  terminal-count carry: high when count is at max and cnt_en is high.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (ports clk and rstn).
- Reset:
  - On a rising clk with rstn=0, count <= 0. Reset has priority over cnt_en.
  - rstn has no effect between clock edges; no asynchronous clear.
  - Reset asserted mid-count clears to 0 on the next edge regardless of the current value.
- Count:
  - On a rising clk with rstn=1 and cnt_en=1, count <= count+1, modulo 2^WIDTH.
  - 4'hF wraps to 4'h0 with no saturation.
  - With rstn=1 and cnt_en=0, count holds its value.
- Latency: one clock from a sampled cnt_en to the updated count.
- Carry:
  - Combinational: carry = cnt_en AND (count == 4'hF). It is not registered.
  - It is high during the cycle whose rising edge causes the F->0 wrap.
  - When it drives the next stage's cnt_en, the upper stage increments on the same edge the lower stage wraps, giving correct synchronous cascading.
  - carry is 0 whenever count != F or cnt_en = 0.
  - During reset, carry still follows the formula. Reset forces count to 0 at the edge, so carry is 0 from the following cycle.
- Power-up: count is undefined until the first clock edge with rstn=0. The bench applies reset before checking values.
- Inputs changing between edges have no effect on count. carry follows cnt_en combinationally.
- No X-propagation hazards: count is always a defined value after reset.

Decomposition:
- Shared package holds the CNT_WIDTH constant (4) and the CNT_MAX constant (all ones).
- No sub-module needed; the block is a single register plus an incrementer and a compare.
- Optionally provide a wrapper, cntr_cascade, that chains N instances through carry -> cnt_en for wider counting. Use it for verification of cascading only.

Test Plan:
- Reset: hold rstn=0, cnt_en=1 for 3 clocks -> count=0 on every edge, carry=0. Then release rstn -> count=1 after the first edge.
- Full sweep: rstn=1, cnt_en=1 for 17 clocks -> count steps 0,1,...,F,0,1. carry=1 only during the cycle count=F.
- Enable hold: count at 5, drop cnt_en for 4 clocks -> count stays 5, carry=0. Re-assert cnt_en -> 6 on the next edge.
- Carry gating: count=F with cnt_en=0 -> carry=0 and count holds at F. Raise cnt_en -> carry=1 immediately (combinational), count=0 after the edge.
- Mid-run reset: count=A, cnt_en=1, pulse rstn=0 for one edge -> count=0 (reset beats enable). Next edge with rstn=1 -> count=1.
- Random enable: for 100 cycles, drive cnt_en randomly every clock. Compare count against a reference model (increment when cnt_en sampled high, mod 16). Check carry == cnt_en & (count==F) every cycle.
